// File: rtl/rr_switch_allocator_pkg.sv
// Shared NoC constants: router port directions and port-index width derivation.
package rr_switch_allocator_pkg;

  // Router port directions; the value is the port index used on every port-indexed bus.
  typedef enum logic [2:0] {
    RESOURCE = 3'd0,
    NORTH    = 3'd1,
    EAST     = 3'd2,
    SOUTH    = 3'd3,
    WEST     = 3'd4
  } noc_port_e;

  localparam int unsigned NOC_PORT_N = 5;

  // Port-index width, never narrower than one bit so single-port builds still elaborate.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NOC_SEL_W = sel_width(NOC_PORT_N);

endpackage

// File: rtl/rr_switch_allocator_arbiter.sv
// Round-robin arbiter for one switch output: a priority pointer plus a wrap-around scan.
module rr_output_arbiter
  import rr_switch_allocator_pkg::*;
#(
  parameter int unsigned PORT_N = NOC_PORT_N,
  parameter int unsigned SEL_W  = sel_width(PORT_N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [PORT_N-1:0] i_req,
  output logic [PORT_N-1:0] o_gnt,
  output logic              o_valid,
  output logic [SEL_W-1:0]  o_idx
);

  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_nextPtr;

  // Scan inputs starting at the pointer, wrapping at PORT_N, and take the first requester.
  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < int'(PORT_N); k++) begin
      int cand;
      cand = int'(r_ptr) + k;
      if (cand >= int'(PORT_N)) cand = cand - int'(PORT_N);
      if (!o_valid && i_req[cand[SEL_W-1:0]]) begin
        o_valid                 = 1'b1;
        o_gnt[cand[SEL_W-1:0]]  = 1'b1;
        o_idx                   = cand[SEL_W-1:0];
      end
    end
  end

  // The winner's successor becomes top priority; the last port wraps to 0, not to 2^SEL_W.
  always_comb begin
    w_nextPtr = '0;
    if (o_idx != SEL_W'(PORT_N - 1)) w_nextPtr = o_idx + 1'b1;
  end

  // The pointer only moves when this output actually grants.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      r_ptr <= '0;
    else if (o_valid) r_ptr <= w_nextPtr;
  end

endmodule

// File: rtl/rr_switch_allocator.sv
// Switch allocator: per-output round-robin arbitration, zero-latency FIFO pops,
// registered crossbar select and downstream write strobes.
module rr_switch_allocator
  import rr_switch_allocator_pkg::*;
#(
  parameter int unsigned PORT_N = NOC_PORT_N,
  parameter int unsigned SEL_W  = sel_width(PORT_N)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [PORT_N-1:0]       req_i,
  input  logic [PORT_N*SEL_W-1:0] dest_i,
  input  logic [PORT_N-1:0]       nxt_fifo_full_i,
  output logic [PORT_N-1:0]       rd_en_o,
  output logic [PORT_N*SEL_W-1:0] xbar_sel_o,
  output logic [PORT_N-1:0]       wr_en_o,
  output logic                    dest_err_o
);

  logic [SEL_W-1:0]  w_dest     [PORT_N];
  logic [PORT_N-1:0] w_reqToOut [PORT_N];
  logic [PORT_N-1:0] w_gnt      [PORT_N];
  logic [SEL_W-1:0]  w_idx      [PORT_N];
  logic [PORT_N-1:0] w_valid;
  logic [PORT_N-1:0] w_pop;
  logic              w_destErr;

  logic [PORT_N*SEL_W-1:0] r_xbarSel;
  logic [PORT_N-1:0]       r_wrEn;
  logic                    r_destErr;

  // Unpack the per-input destination slices.
  always_comb begin
    for (int i = 0; i < int'(PORT_N); i++) w_dest[i] = dest_i[i*SEL_W +: SEL_W];
  end

  // Route each pending head to its output, masking outputs whose downstream FIFO is full.
  always_comb begin
    for (int o = 0; o < int'(PORT_N); o++) begin
      w_reqToOut[o] = '0;
      for (int i = 0; i < int'(PORT_N); i++) begin
        w_reqToOut[o][i] = req_i[i] && (w_dest[i] == SEL_W'(o)) && !nxt_fifo_full_i[o];
      end
    end
  end

  // Flag any pending head whose destination is not a real port; such heads never match above.
  always_comb begin
    w_destErr = 1'b0;
    for (int i = 0; i < int'(PORT_N); i++) begin
      if (req_i[i] && (int'(w_dest[i]) >= int'(PORT_N))) w_destErr = 1'b1;
    end
  end

  for (genvar o = 0; o < PORT_N; o++) begin : g_arb
    rr_output_arbiter #(
      .PORT_N (PORT_N),
      .SEL_W  (SEL_W)
    ) u_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_req   (w_reqToOut[o]),
      .o_gnt   (w_gnt[o]),
      .o_valid (w_valid[o]),
      .o_idx   (w_idx[o])
    );
  end

  // An input pops when it wins any output; popping is suppressed while reset is held.
  always_comb begin
    w_pop = '0;
    for (int o = 0; o < int'(PORT_N); o++) w_pop = w_pop | w_gnt[o];
    rd_en_o = rst_ni ? w_pop : '0;
  end

  // Register this cycle's grants so select and write line up with the registered crossbar data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_xbarSel <= '0;
      r_wrEn    <= '0;
      r_destErr <= 1'b0;
    end else begin
      r_wrEn    <= w_valid;
      r_destErr <= w_destErr;
      for (int o = 0; o < int'(PORT_N); o++) begin
        if (w_valid[o]) r_xbarSel[o*SEL_W +: SEL_W] <= w_idx[o];
      end
    end
  end

  assign xbar_sel_o = r_xbarSel;
  assign wr_en_o    = r_wrEn;
  assign dest_err_o = r_destErr;

endmodule

// File: tb/tb_rr_switch_allocator.sv
// Self-checking bench for rr_switch_allocator against a round-robin reference model.
module tb_rr_switch_allocator;

  localparam int PN = 5;
  localparam int SW = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  logic [PN-1:0]   req_i = '0;
  logic [PN*SW-1:0] dest_i = '0;
  logic [PN-1:0]   nxt_fifo_full_i = '0;
  logic [PN-1:0]   rd_en_o;
  logic [PN*SW-1:0] xbar_sel_o;
  logic [PN-1:0]   wr_en_o;
  logic            dest_err_o;

  int cmpCount = 0;
  int errCount = 0;

  int          mPtr [PN];
  int          mSel [PN];
  logic [PN-1:0] mWr;
  logic        mErr;
  logic [PN-1:0] obsRd;

  rr_switch_allocator #(.PORT_N(PN), .SEL_W(SW)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_i           (req_i),
    .dest_i          (dest_i),
    .nxt_fifo_full_i (nxt_fifo_full_i),
    .rd_en_o         (rd_en_o),
    .xbar_sel_o      (xbar_sel_o),
    .wr_en_o         (wr_en_o),
    .dest_err_o      (dest_err_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Count a comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    cmpCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [PN*SW-1:0] mkDest(input int d0, input int d1, input int d2, input int d3, input int d4);
    logic [PN*SW-1:0] v;
    v[2:0]   = d0[2:0];
    v[5:3]   = d1[2:0];
    v[8:6]   = d2[2:0];
    v[11:9]  = d3[2:0];
    v[14:12] = d4[2:0];
    return v;
  endfunction

  function automatic logic [PN*SW-1:0] modelSel();
    logic [PN*SW-1:0] v;
    for (int o = 0; o < PN; o++) v[o*SW +: SW] = mSel[o][SW-1:0];
    return v;
  endfunction

  task automatic modelReset();
    for (int o = 0; o < PN; o++) begin
      mPtr[o] = 0;
      mSel[o] = 0;
    end
    mWr  = '0;
    mErr = 1'b0;
  endtask

  // Hold reset, check the cleared state with requests pending, then release away from a clock edge.
  task automatic resetDut();
    rst_ni = 1'b0;
    req_i = '1;
    dest_i = mkDest(1, 2, 3, 4, 0);
    nxt_fifo_full_i = '0;
    #1;
    checkOutput("rst_rd_en", rd_en_o, 0);
    checkOutput("rst_wr_en", wr_en_o, 0);
    checkOutput("rst_xbar_sel", xbar_sel_o, 0);
    checkOutput("rst_dest_err", dest_err_o, 0);
    modelReset();
    req_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Drive one cycle of inputs, check the pop strobes before the edge and registered outputs after it.
  task automatic applyStimulus(input logic [PN-1:0] req, input logic [PN*SW-1:0] dest, input logic [PN-1:0] full);
    logic [PN-1:0] expRd;
    logic [PN-1:0] expWr;
    logic          expErr;
    req_i = req;
    dest_i = dest;
    nxt_fifo_full_i = full;
    #1;
    expRd = '0;
    expWr = '0;
    expErr = 1'b0;
    for (int i = 0; i < PN; i++) begin
      if (req[i] && int'(dest[i*SW +: SW]) >= PN) expErr = 1'b1;
    end
    for (int o = 0; o < PN; o++) begin
      bit found;
      found = 1'b0;
      if (!full[o]) begin
        for (int k = 0; k < PN; k++) begin
          int c;
          c = (mPtr[o] + k) % PN;
          if (!found && req[c] && int'(dest[c*SW +: SW]) == o) begin
            found = 1'b1;
            expRd[c] = 1'b1;
            expWr[o] = 1'b1;
            mSel[o] = c;
            mPtr[o] = (c + 1) % PN;
          end
        end
      end
    end
    obsRd = rd_en_o;
    checkOutput("rd_en", rd_en_o, expRd);
    @(posedge clk_i);
    #1;
    mWr = expWr;
    mErr = expErr;
    checkOutput("wr_en", wr_en_o, mWr);
    checkOutput("xbar_sel", xbar_sel_o, modelSel());
    checkOutput("dest_err", dest_err_o, mErr);
  endtask

  initial begin
    modelReset();
    #2;
    resetDut();

    // Single request: input 0 to output 2.
    applyStimulus(5'b00001, mkDest(2, 0, 0, 0, 0), 5'b00000);
    checkOutput("single_rd", obsRd, 5'b00001);
    checkOutput("single_wr", wr_en_o, 5'b00100);
    checkOutput("single_sel2", xbar_sel_o[8:6], 0);

    // Inputs 1, 3, 4 contending for output 0, then the pointer must have wrapped to 0.
    resetDut();
    applyStimulus(5'b11010, mkDest(0, 0, 0, 0, 0), 5'b00000);
    checkOutput("rr_first", obsRd, 5'b00010);
    applyStimulus(5'b11010, mkDest(0, 0, 0, 0, 0), 5'b00000);
    checkOutput("rr_second", obsRd, 5'b01000);
    applyStimulus(5'b11010, mkDest(0, 0, 0, 0, 0), 5'b00000);
    checkOutput("rr_third", obsRd, 5'b10000);
    checkOutput("rr_third_sel0", xbar_sel_o[2:0], 4);
    applyStimulus(5'b00011, mkDest(0, 0, 0, 0, 0), 5'b00000);
    checkOutput("rr_wrap", obsRd, 5'b00001);

    // Full output blocks the grant until it drains.
    applyStimulus(5'b00100, mkDest(0, 0, 3, 0, 0), 5'b01000);
    checkOutput("full_rd", obsRd, 5'b00000);
    checkOutput("full_wr", wr_en_o, 5'b00000);
    applyStimulus(5'b00100, mkDest(0, 0, 3, 0, 0), 5'b00000);
    checkOutput("drain_rd", obsRd, 5'b00100);
    checkOutput("drain_wr", wr_en_o, 5'b01000);

    // Parallel grants to distinct outputs.
    applyStimulus(5'b00101, mkDest(1, 0, 4, 0, 0), 5'b00000);
    checkOutput("par_rd", obsRd, 5'b00101);
    checkOutput("par_wr", wr_en_o, 5'b10010);

    // Out-of-range destination.
    applyStimulus(5'b00001, mkDest(6, 0, 0, 0, 0), 5'b00000);
    checkOutput("bad_rd", obsRd, 5'b00000);
    checkOutput("bad_err", dest_err_o, 1);

    // Reset between the grant and the registered write; pointers must return to 0.
    applyStimulus(5'b00001, mkDest(2, 0, 0, 0, 0), 5'b00000);
    checkOutput("pre_rst_wr", wr_en_o, 5'b00100);
    rst_ni = 1'b0;
    #1;
    checkOutput("mid_rst_wr", wr_en_o, 0);
    checkOutput("mid_rst_sel", xbar_sel_o, 0);
    checkOutput("mid_rst_rd", rd_en_o, 0);
    modelReset();
    req_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    applyStimulus(5'b00011, mkDest(2, 2, 0, 0, 0), 5'b00000);
    checkOutput("post_rst_first", obsRd, 5'b00001);

    // Randomized traffic with occasional bad destinations and sparse full flags.
    for (int n = 0; n < 400; n++) begin
      logic [PN*SW-1:0] d;
      for (int i = 0; i < PN; i++) begin
        int v;
        v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        d[i*SW +: SW] = v[SW-1:0];
      end
      applyStimulus(PN'($urandom), d, PN'($urandom & $urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/rr_switch_allocator.md
RR_SWITCH_ALLOCATOR -- requirements
Module: rr_switch_allocator

Interface
REQ-001 The block SHALL have parameter PORT_N, default 5, giving the number of switch input and output ports.
REQ-002 The block SHALL have parameter SEL_W, default $clog2(PORT_N), giving the port-index width.
REQ-003 The block SHALL have port clk_i, input, width 1, as the single clock.
REQ-004 The block SHALL have port rst_ni, input, width 1, as the reset; reset is asynchronous and active-low.
REQ-005 The block SHALL have port req_i, input, width PORT_N, where bit i is input FIFO i non-empty, i.e. head packet pending.
REQ-006 The block SHALL have port dest_i, input, width PORT_N*SEL_W, where slice i is the router-computed output index for input i's head packet.
REQ-007 The block SHALL have port nxt_fifo_full_i, input, width PORT_N, where bit o is downstream FIFO o full.
REQ-008 The block SHALL have port rd_en_o, output, width PORT_N, as the combinational pop strobe to input FIFO i.
REQ-009 The block SHALL have port xbar_sel_o, output, width PORT_N*SEL_W, where slice o is the registered crossbar source input for output o.
REQ-010 The block SHALL have port wr_en_o, output, width PORT_N, as the registered write strobe to downstream FIFO o.
REQ-011 The block SHALL have port dest_err_o, output, width 1, as a registered pulse on any request with dest >= PORT_N.

Function
REQ-012 Output o SHALL be eligible in a cycle only when nxt_fifo_full_i[o]==0.
REQ-013 Input i SHALL request output o when req_i[i]==1, dest_i slice i == o and o < PORT_N.
REQ-014 Each output SHALL keep a priority pointer ptr[o] (SEL_W bits); the winner SHALL be the first requesting input scanning ptr[o], ptr[o]+1, ... modulo PORT_N.
REQ-015 The modulo-PORT_N wrap SHALL be explicit (PORT_N-1 -> 0) and SHALL NOT be 2^SEL_W wrap.
REQ-016 rd_en_o[i] SHALL equal 1 in the same cycle that input i wins any eligible output (zero latency, pops the FIFO at the clock edge).
REQ-017 At most one grant SHALL be issued per output per cycle; each input holds one destination, so at most one grant SHALL be issued per input per cycle.
REQ-018 On a grant of input g to output o, ptr[o] SHALL update to (g+1) mod PORT_N at the next edge; without a grant, ptr[o] SHALL hold.
REQ-019 Grant in cycle N to output o SHALL register xbar_sel_o[o]=g and wr_en_o[o]=1, both visible in cycle N+1 aligned with the registered crossbar data (one-cycle latency).
REQ-020 When output o has no grant, wr_en_o[o] SHALL be 0 next cycle and xbar_sel_o[o] SHALL hold its value.
REQ-021 Losing inputs SHALL keep rd_en_o=0 and SHALL be retried with no loss of request.
REQ-022 An output full in the grant cycle SHALL receive no grant; full rising in cycle N+1 after a grant SHALL NOT cancel the registered wr_en_o; the downstream FIFO headroom covers this.
REQ-023 dest >= PORT_N with req_i high SHALL produce no grant and no pop, and SHALL set dest_err_o=1 in the next cycle.
REQ-024 Simultaneous grants to distinct outputs in one cycle SHALL all be issued (parallel allocation).

Reset
REQ-025 On rst_ni low, immediately and independent of clk_i: all ptr[o]=0, wr_en_o=0, xbar_sel_o=0, dest_err_o=0.
REQ-026 rd_en_o SHALL be forced 0 while rst_ni is low.
REQ-027 Reset mid-transfer SHALL drop any registered pending wr_en_o with no partial write.
REQ-028 The first grant after reset release SHALL favour input 0.

Structure
REQ-029 A shared noc package SHALL hold the port-direction constants (RESOURCE, NORTH, EAST, SOUTH, WEST indices) and the SEL_W derivation used by the router and this block.
REQ-030 One sub-module rr_output_arbiter (per-output pointer plus wrap-around priority scan) SHALL be instantiated PORT_N times via generate.

Verification
REQ-031 Bench: reset, then req_i=00001, dest0=2, full=0 -> rd_en_o=00001 same cycle; next cycle wr_en_o=00100, xbar_sel[2]=0.
REQ-032 Bench: inputs 1, 3, 4 all to output 0 held for 3 cycles -> grants 1, 3, 4 in order; ptr[0]=0 after the third (wraps at 4 -> 0).
REQ-033 Bench: nxt_fifo_full_i[3]=1 with input 2 to output 3 -> no rd_en/wr_en; full drops -> grant next cycle.
REQ-034 Bench: input 0 to output 1 and input 2 to output 4 simultaneously -> rd_en_o=00101; next cycle wr_en_o=10010.
REQ-035 Bench: dest0=6 (PORT_N=5) with req -> rd_en_o=0; dest_err_o=1 one cycle later.
REQ-036 Bench: assert rst_ni low between the grant and the registered write -> wr_en_o=0 immediately; pointers=0.
